// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
//   instr, status        : datapath -> controller (fetched word, ALU flags {N,Z,C,V})
//   regRW .. illegal     : controller -> datapath (registered control outputs)
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic [3:0]  status;
    logic        regRW;
    logic        ALUsrc;
    logic [1:0]  immsrc;
    logic [4:0]  ALUop;
    logic        mRW;
    logic        wb;
    logic        pcsrc;
    logic        pc_en;
    logic        illegal;

    modport master (
        input  instr, status,
        output regRW, ALUsrc, immsrc, ALUop, mRW, wb, pcsrc, pc_en, illegal
    );
    modport slave (
        output instr, status,
        input  regRW, ALUsrc, immsrc, ALUop, mRW, wb, pcsrc, pc_en, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) upstream of the datapath.
// Every control output is a register loaded with the decode of the state being
// entered, so outputs are stable for the whole state cycle.
// Ports:
//   clk   : clock, posedge
//   rst   : synchronous active-low reset
//   bus   : multicycle_ctrl_if.master (instr/status in, datapath controls out)
//   cyc_cnt, ret_cnt : performance counters, present only with CTRL_PERF_EN
// Parameters: HALT_ON_ILLEGAL (1 = park in HALT, 0 = retire as NOP),
//             CNT_W (counter width, only with CTRL_PERF_EN).
// Optional feature macro: CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
`ifdef CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  ret_cnt
`endif
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR  = 5'd3,
                           ALU_XOR = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SLT = 5'd7;

    // Only BEQ/BNE are supported under BRANCH.
    function automatic logic is_illegal(input logic [31:0] w);
        case (w[6:0])
            OP_R, OP_I, OP_LW, OP_SW: is_illegal = 1'b0;
            OP_BR:                    is_illegal = (w[14:13] != 2'b00);
            default:                  is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [4:0] alu_fn(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:         alu_fn = sub ? ALU_SUB : ALU_ADD;
            3'b001:         alu_fn = ALU_SLL;
            3'b010, 3'b011: alu_fn = ALU_SLT;
            3'b100:         alu_fn = ALU_XOR;
            3'b101:         alu_fn = ALU_SRL;
            3'b110:         alu_fn = ALU_OR;
            default:        alu_fn = ALU_AND;
        endcase
    endfunction

    state_t      state, next_state;
    logic [31:0] ir, nir;
    logic [6:0]  op;
    logic        ill;
    logic        regrw_q, alusrc_q, mrw_q, wb_q, pcsrc_q, pcen_q, illegal_q;
    logic [1:0]  immsrc_q;
    logic [4:0]  aluop_q;
    logic        regrw_d, alusrc_d, mrw_d, wb_d, pcsrc_d, pcen_d, illegal_d;
    logic [1:0]  immsrc_d;
    logic [4:0]  aluop_d;

    // Fields of ir the controller never looks at.
    logic unused_bits;
    assign unused_bits = ^{ir[31], ir[29:15], ir[11:7], bus.status[3], bus.status[1:0]};

    always_comb begin
        // ir as it will look in the state being entered (loaded during FETCH).
        nir        = (state == S_FETCH) ? bus.instr : ir;
        op         = nir[6:0];
        ill        = is_illegal(nir);
        next_state = state;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: if (ill) next_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                      else     next_state = S_EXEC;
            S_EXEC:   if (op == OP_BR)                     next_state = S_FETCH;
                      else if (op == OP_LW || op == OP_SW) next_state = S_MEM;
                      else                                 next_state = S_WB;
            S_MEM:    next_state = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase

        regrw_d   = 1'b0;
        alusrc_d  = 1'b1;
        immsrc_d  = 2'b00;
        aluop_d   = ALU_ADD;
        mrw_d     = 1'b1;
        wb_d      = 1'b0;
        pcsrc_d   = 1'b1;
        pcen_d    = 1'b0;
        illegal_d = illegal_q | (state == S_DECODE && ill);

        // ALU controls are held identical across EXEC, MEM and WB.
        if (next_state == S_EXEC || next_state == S_MEM || next_state == S_WB) begin
            case (op)
                OP_R:    aluop_d = alu_fn(nir[14:12], nir[30]);
                OP_I:    begin alusrc_d = 1'b0; aluop_d = alu_fn(nir[14:12], 1'b0); end
                OP_LW:   alusrc_d = 1'b0;
                OP_SW:   begin alusrc_d = 1'b0; immsrc_d = 2'b01; end
                OP_BR:   begin immsrc_d = 2'b10; aluop_d = ALU_SUB; end
                default: ;
            endcase
        end

        case (next_state)
            S_DECODE: if (ill && !HALT_ON_ILLEGAL) pcen_d = 1'b1;
            // Branch resolves in EXEC: taken when Z xor BNE; taken selects PC+imm.
            S_EXEC:   if (op == OP_BR) begin
                          pcen_d  = 1'b1;
                          pcsrc_d = ~(bus.status[2] ^ nir[12]);
                      end
            S_MEM:    if (op == OP_SW) begin mrw_d = 1'b0; pcen_d = 1'b1; end
            S_WB:     begin regrw_d = 1'b1; wb_d = (op == OP_LW); pcen_d = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_FETCH;
            ir        <= '0;
            regrw_q   <= 1'b0;
            alusrc_q  <= 1'b1;
            immsrc_q  <= 2'b00;
            aluop_q   <= ALU_ADD;
            mrw_q     <= 1'b1;
            wb_q      <= 1'b0;
            pcsrc_q   <= 1'b1;
            pcen_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            ir        <= nir;
            regrw_q   <= regrw_d;
            alusrc_q  <= alusrc_d;
            immsrc_q  <= immsrc_d;
            aluop_q   <= aluop_d;
            mrw_q     <= mrw_d;
            wb_q      <= wb_d;
            pcsrc_q   <= pcsrc_d;
            pcen_q    <= pcen_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.regRW   = regrw_q;
    assign bus.ALUsrc  = alusrc_q;
    assign bus.immsrc  = immsrc_q;
    assign bus.ALUop   = aluop_q;
    assign bus.mRW     = mrw_q;
    assign bus.wb      = wb_q;
    assign bus.pcsrc   = pcsrc_q;
    assign bus.pc_en   = pcen_q;
    assign bus.illegal = illegal_q;

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != S_HALT) cyc_cnt <= cyc_cnt + 1'b1;
            if (pcen_q)          ret_cnt <= ret_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of instructions with hand-derived
// per-cycle expectations, plus illegal/HALT and reset-mid-instruction sequences.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    multicycle_ctrl_if bus();

`ifdef CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    multicycle_ctrl #(
        .HALT_ON_ILLEGAL(1'b1)
`ifdef CTRL_PERF_EN
        ,
        .CNT_W(32)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CTRL_PERF_EN
        ,
        .cyc_cnt(cyc_cnt),
        .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  status;
        int          len;      // cycle (1-based from FETCH) of the pc_en pulse
        int          reg_cyc;  // cycle with regRW=1, 0 = never
        int          mw_cyc;   // cycle with mRW=0, 0 = never
        logic        wb;
        logic        pcsrc;
        logic        alusrc;
        logic [1:0]  immsrc;
        logic [4:0]  aluop;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input string n, input logic [31:0] i, input logic [3:0] s,
                                input int l, input int rc, input int mc, input logic w,
                                input logic ps, input logic as, input logic [1:0] im,
                                input logic [4:0] ao);
        vec_t v;
        v.name = n; v.instr = i; v.status = s; v.len = l; v.reg_cyc = rc; v.mw_cyc = mc;
        v.wb = w; v.pcsrc = ps; v.alusrc = as; v.immsrc = im; v.aluop = ao;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at the negedge of the FETCH cycle; leaves at the negedge of the next FETCH.
    task automatic run_vec(input vec_t v);
        bus.instr  = v.instr;
        bus.status = v.status;
        for (int c = 1; c <= v.len; c++) begin
            chk($sformatf("%s c%0d pc_en", v.name, c), bus.pc_en, c == v.len);
            chk($sformatf("%s c%0d regRW", v.name, c), bus.regRW, c == v.reg_cyc);
            chk($sformatf("%s c%0d mRW", v.name, c), bus.mRW, c != v.mw_cyc);
            chk($sformatf("%s c%0d wb", v.name, c), bus.wb, (c == v.reg_cyc) && v.wb);
            chk($sformatf("%s c%0d illegal", v.name, c), bus.illegal, 1'b0);
            if (c >= 3) begin
                chk($sformatf("%s c%0d ALUsrc", v.name, c), bus.ALUsrc, v.alusrc);
                chk($sformatf("%s c%0d immsrc", v.name, c), bus.immsrc, v.immsrc);
                chk($sformatf("%s c%0d ALUop", v.name, c), bus.ALUop, v.aluop);
            end
            if (c == v.len)
                chk($sformatf("%s pcsrc", v.name), bus.pcsrc, v.pcsrc);
            step();
        end
    endtask

    initial begin
        //                name      instr         status   len rc mc wb ps as imm    op
        vecs[0]  = mk("add",    32'h002081B3, 4'b0000, 4, 4, 0, 0, 1, 1, 2'b00, 5'd0);
        vecs[1]  = mk("lw",     32'h00802283, 4'b0000, 5, 5, 0, 1, 1, 0, 2'b00, 5'd0);
        vecs[2]  = mk("sw",     32'h00502223, 4'b0000, 4, 0, 4, 0, 1, 0, 2'b01, 5'd0);
        vecs[3]  = mk("beq_t",  32'h00000463, 4'b0100, 3, 0, 0, 0, 0, 1, 2'b10, 5'd1);
        vecs[4]  = mk("beq_nt", 32'h00000463, 4'b0000, 3, 0, 0, 0, 1, 1, 2'b10, 5'd1);
        vecs[5]  = mk("beq_nz", 32'h00000463, 4'b1011, 3, 0, 0, 0, 1, 1, 2'b10, 5'd1);
        vecs[6]  = mk("bne_z",  32'h00001463, 4'b0100, 3, 0, 0, 0, 1, 1, 2'b10, 5'd1);
        vecs[7]  = mk("bne_t",  32'h00001463, 4'b0000, 3, 0, 0, 0, 0, 1, 2'b10, 5'd1);
        vecs[8]  = mk("sub",    32'h402081B3, 4'b0000, 4, 4, 0, 0, 1, 1, 2'b00, 5'd1);
        vecs[9]  = mk("andi",   32'h0FF0F093, 4'b0000, 4, 4, 0, 0, 1, 0, 2'b00, 5'd2);
        vecs[10] = mk("xor",    32'h0020C1B3, 4'b0000, 4, 4, 0, 0, 1, 1, 2'b00, 5'd4);
        vecs[11] = mk("or",     32'h0020E1B3, 4'b0000, 4, 4, 0, 0, 1, 1, 2'b00, 5'd3);
        vecs[12] = mk("slli",   32'h00309093, 4'b0000, 4, 4, 0, 0, 1, 0, 2'b00, 5'd5);

        bus.instr  = 32'h0;
        bus.status = 4'b0;
        rst = 1'b0;
        step();
        step();
        chk("rst regRW", bus.regRW, 1'b0);
        chk("rst mRW", bus.mRW, 1'b1);
        chk("rst pc_en", bus.pc_en, 1'b0);
        chk("rst pcsrc", bus.pcsrc, 1'b1);
        chk("rst wb", bus.wb, 1'b0);
        chk("rst ALUsrc", bus.ALUsrc, 1'b1);
        chk("rst immsrc", bus.immsrc, 2'b00);
        chk("rst ALUop", bus.ALUop, 5'd0);
        chk("rst illegal", bus.illegal, 1'b0);
`ifdef CTRL_PERF_EN
        chk("rst ret_cnt", ret_cnt, 32'd0);
`endif
        rst = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Illegal opcode: parks in HALT with all enables low until reset.
        bus.instr = 32'hFFFFFFFF;
        step();
        chk("ill decode pc_en", bus.pc_en, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("halt%0d illegal", c), bus.illegal, 1'b1);
            chk($sformatf("halt%0d pc_en", c), bus.pc_en, 1'b0);
            chk($sformatf("halt%0d regRW", c), bus.regRW, 1'b0);
            chk($sformatf("halt%0d mRW", c), bus.mRW, 1'b1);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("halt rst illegal", bus.illegal, 1'b0);
        chk("halt rst pc_en", bus.pc_en, 1'b0);
        run_vec(vecs[0]);

        // Reset while a SW is in MEM.
        bus.instr = vecs[2].instr;
        step();
        step();
        step();
        chk("sw mem mRW", bus.mRW, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("sw rst mRW", bus.mRW, 1'b1);
        chk("sw rst pc_en", bus.pc_en, 1'b0);
        chk("sw rst regRW", bus.regRW, 1'b0);
`ifdef CTRL_PERF_EN
        chk("sw rst ret_cnt", ret_cnt, 32'd0);
        chk("sw rst cyc_cnt", cyc_cnt, 32'd0);
`endif
        // FSM must be in FETCH now: three full instructions retire cleanly.
        run_vec(vecs[0]);
        run_vec(vecs[8]);
        run_vec(vecs[9]);
`ifdef CTRL_PERF_EN
        chk("perf ret_cnt", ret_cnt, 32'd3);
        chk("perf cyc_cnt", cyc_cnt, 32'd12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
